// File: rtl/sr_seq.sv
// Sequential right shifter: loads a W-bit word and shifts it right one bit per clock,
// with zero or sign fill, then pulses done for one cycle with the result on y.
module sr_seq #(
    parameter int W  = 4,
    parameter int AW = $clog2(W) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  a,
    input  logic [AW-1:0] amt,
    input  logic          arith,
    output logic [W-1:0]  y,
    output logic          sout,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [AW-1:0] W_AMT = AW'(W);
    localparam logic [AW-1:0] ONE   = AW'(1);

    state_t        state;
    state_t        state_next;
    logic [W-1:0]  sreg;
    logic [AW-1:0] cnt;
    logic          fill;
    logic [AW-1:0] amt_sat;

    // Amounts of W or more all behave like a full-width shift.
    assign amt_sat = (amt >= W_AMT) ? W_AMT : amt;

    // NOTE: state and datapath registers use non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (amt_sat == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == ONE) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= '0;
            cnt  <= '0;
            fill <= 1'b0;
            sout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sreg <= a;
                        cnt  <= amt_sat;
                        fill <= arith & a[W-1];
                        sout <= 1'b0;
                    end
                end
                SHIFT: begin
                    sreg <= {fill, sreg[W-1:1]};
                    sout <= sreg[0];
                    cnt  <= cnt - ONE;
                end
                default: ;
            endcase
        end
    end

    assign y    = sreg;
    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule
